// File: rtl/core_bus_pkg.sv
// Shared types and defaults for the core bus arbiter and its requesters.
// core_cmd_t is a convenience bundle at the default widths for requester-side code.
package core_bus_pkg;

    localparam int INSTR_W = 8;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 32;

    localparam logic [INSTR_W-1:0] OP_NOP = 8'h00;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  value;
    } core_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } arb_state_e;

endpackage

// File: rtl/core_bus_arbiter_if.sv
// Requester-side handshake plus core-side command/result bus of the arbiter.
// The arbiter uses the slave view; requesters and the core side use master.
interface core_bus_arbiter_if #(
    parameter int N_REQ   = 2,
    parameter int INSTR_W = core_bus_pkg::INSTR_W,
    parameter int ADDR_W  = core_bus_pkg::ADDR_W,
    parameter int DATA_W  = core_bus_pkg::DATA_W
);

    logic [N_REQ-1:0]         req_i;
    logic [N_REQ*INSTR_W-1:0] instruction_i;
    logic [N_REQ*ADDR_W-1:0]  address_i;
    logic [N_REQ*DATA_W-1:0]  value_i;
    logic [N_REQ-1:0]         gnt_o;
    logic [N_REQ-1:0]         done_o;
    logic [DATA_W-1:0]        result_o;
    logic [INSTR_W-1:0]       instruction_o;
    logic [ADDR_W-1:0]        address_o;
    logic [DATA_W-1:0]        value_o;
    logic [DATA_W-1:0]        result_i;
    logic                     busy_o;

    modport slave (
        input  req_i, instruction_i, address_i, value_i, result_i,
        output gnt_o, done_o, result_o, instruction_o, address_o, value_o, busy_o
    );

    modport master (
        output req_i, instruction_i, address_i, value_i, result_i,
        input  gnt_o, done_o, result_o, instruction_o, address_o, value_o, busy_o
    );

endinterface

// File: rtl/core_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        // Offset N_REQ revisits i_last itself, so a lone requester can win again.
        for (int i = 1; i <= N_REQ; i++) begin
            if (!o_valid && i_req[IDX_W'((int'(i_last) + i) % N_REQ)]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'((int'(i_last) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// Round-robin owner of the internal core bus: grants one requester, holds its command
// for RESULT_LAT cycles, captures the core result and returns it with a done pulse.
module core_bus_arbiter
    import core_bus_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int INSTR_W    = core_bus_pkg::INSTR_W,
    parameter int ADDR_W     = core_bus_pkg::ADDR_W,
    parameter int DATA_W     = core_bus_pkg::DATA_W,
    parameter int RESULT_LAT = 2
) (
    input logic               clk_i,
    input logic               rst_ni,
    core_bus_arbiter_if.slave bus
);

    localparam int         IDX_W    = $clog2(N_REQ);
    localparam logic [7:0] CNT_LOAD = 8'(RESULT_LAT - 1);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [IDX_W-1:0]   r_winner;
    logic [IDX_W-1:0]   r_last;
    logic [7:0]         r_cnt;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_value;
    logic [DATA_W-1:0]  r_result;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic [N_REQ-1:0]   w_onehot;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (bus.req_i),
        .i_last  (r_last),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_onehot = N_REQ'(1) << r_winner;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_winner <= '0;
            r_last   <= IDX_W'(N_REQ - 1);
            r_cnt    <= '0;
            r_instr  <= '0;
            r_addr   <= '0;
            r_value  <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    // The command is snapshotted here; later input changes are ignored.
                    if (w_pick_valid) begin
                        r_winner <= w_pick_idx;
                        r_instr  <= bus.instruction_i[int'(w_pick_idx) * INSTR_W +: INSTR_W];
                        r_addr   <= bus.address_i[int'(w_pick_idx) * ADDR_W +: ADDR_W];
                        r_value  <= bus.value_i[int'(w_pick_idx) * DATA_W +: DATA_W];
                    end
                end
                ISSUE: r_cnt <= CNT_LOAD;
                WAIT: begin
                    if (r_cnt == 8'd0) begin
                        r_result <= bus.result_i;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                RESPOND: r_last <= r_winner;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        bus.gnt_o         = '0;
        bus.done_o        = '0;
        bus.instruction_o = INSTR_W'(OP_NOP);
        bus.address_o     = '0;
        bus.value_o       = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.gnt_o         = w_onehot;
                bus.instruction_o = r_instr;
                bus.address_o     = r_addr;
                bus.value_o       = r_value;
                w_state_nxt       = WAIT;
            end
            WAIT: begin
                bus.instruction_o = r_instr;
                bus.address_o     = r_addr;
                bus.value_o       = r_value;
                if (r_cnt == 8'd0) begin
                    w_state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                bus.done_o  = w_onehot;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.result_o = r_result;
    assign bus.busy_o   = (r_state != IDLE);

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Shares the internal core bus (instruction/address/value out, result in) between N_REQ requesters, e.g. the SPI instruction handler and an autonomous stream/sequencer engine.
- Round-robin arbitration with a req/gnt/done handshake.
- Holds each granted command on the bus for a fixed result latency, captures the result and returns it to the winner.
- Sits between the requesters and the core_interface instances, all on the system clock.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- INSTR_W, 8, instruction width.
- ADDR_W, 24, address width.
- DATA_W, 32, value/result width.
- RESULT_LAT, 2, cycles the command is held on the bus before result_i is sampled (1..255).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, synchronous, active-low.
- req_i  in  N_REQ  per-requester request; level, held until gnt_o.
- instruction_i  in  N_REQ*INSTR_W  packed per-requester instruction; slot k at bits [k*INSTR_W +: INSTR_W].
- address_i  in  N_REQ*ADDR_W  packed per-requester address.
- value_i  in  N_REQ*DATA_W  packed per-requester value.
- gnt_o  out  N_REQ  one-hot, one-cycle pulse: command accepted.
- done_o  out  N_REQ  one-hot, one-cycle pulse: result_o valid for that requester.
- result_o  out  DATA_W  last captured result; stable until the next capture.
- instruction_o  out  INSTR_W  bus instruction to cores.
- address_o  out  ADDR_W  bus address.
- value_o  out  DATA_W  bus value.
- result_i  in  DATA_W  bus result from cores.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
Reset (rst_ni=0 at a clk_i edge):
- state=IDLE.
- gnt_o, done_o, result_o, address_o, value_o = 0; busy_o=0.
- instruction_o=OP_NOP (0x00).
- last_grant=N_REQ-1, so requester 0 wins first.
- Reset mid-transaction aborts it: no done_o is issued, and the bus returns to NOP on the next cycle.

FSM states: IDLE, ISSUE, WAIT, RESPOND.

IDLE:
- Bus drives OP_NOP/0/0.
- If req_i≠0: the winner is the first set bit searching last_grant+1, last_grant+2, … modulo N_REQ.
- Latch the winner index and its instruction/address/value slice -> ISSUE.

ISSUE (1 cycle):
- gnt_o[winner]=1.
- Bus drives the latched command.
- cnt=RESULT_LAT-1 -> WAIT.

WAIT:
- Bus keeps driving the latched command.
- If cnt==0: result_o<=result_i -> RESPOND; else cnt--.

RESPOND (1 cycle):
- done_o[winner]=1, result_o valid.
- Bus returns to OP_NOP/0/0.
- last_grant<=winner -> IDLE.

Latency:
- req sampled in IDLE at edge t: gnt_o high cycle t+1; result_i sampled RESULT_LAT cycles after ISSUE; done_o high cycle t+2+RESULT_LAT.
- Minimum spacing between grants: RESULT_LAT+3 cycles.

Handshake and boundary rules:
- Requests are not accepted outside IDLE; they wait, with no queueing beyond the level of req_i.
- Command inputs are sampled only in the IDLE->ISSUE cycle; later changes are ignored.
- req dropped before gnt: that requester is simply not selected; no error.
- req still high at RESPOND: re-arbitrated in the next IDLE, so other pending requesters win first (fairness); a lone requester is re-granted.
- Simultaneous requests: strict round-robin; no requester waits more than N_REQ-1 transactions.
- An instruction of OP_NOP from a requester is still a full transaction, with the same timing.
- gnt_o and done_o are always one-hot or zero and never overlap.

Decomposition:
- Package core_bus_pkg holds:
  - OP_NOP;
  - default widths INSTR_W/ADDR_W/DATA_W;
  - typedef core_cmd_t = struct {instr, addr, value};
  - enum arb_state_e {IDLE, ISSUE, WAIT, RESPOND}.
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs: req vector and last index. Outputs: winner index and a valid flag.

Test Plan:
- Reset: hold rst_ni=0 3 cycles with req_i=2'b11 -> gnt_o=0, done_o=0, busy_o=0, instruction_o=0x00. Release -> req0 granted first.
- Single request: req0 with {0x02, 0x000003, 0xDEADBEEF}, RESULT_LAT=2, result_i=0x12345678 -> gnt_o[0] at t+1; bus shows the command for 3 cycles; done_o[0] at t+4 with result_o=0x12345678; bus back to 0x00.
- Contention: req_i=2'b11 held continuously -> grants alternate 0,1,0,1; four done pulses with correct result_o each; spacing RESULT_LAT+3.
- Mid-transaction input change: after gnt_o[0], change value_i slot0 to 0 -> value_o stays 0xDEADBEEF until RESPOND.
- Withdrawn request: req1 pulsed one cycle while the arbiter is in WAIT for req0 -> req1 never granted; arbiter returns to IDLE with busy_o=0.
- Reset mid-WAIT: assert rst_ni=0 during WAIT -> no done_o; next cycle instruction_o=0x00, result_o=0.
